// File: rtl/ser_pkg.sv
// Shared types and helpers for the bit serializer: state encoding and the
// index-width helper used to size BIT_IDX.
package ser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_GAP   = 2'b10
   } state_t;

   localparam int GAP_CNT_W = 4;

   // Never returns zero so a bit index is always at least one bit wide
   function automatic int idx_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the single-bit detectors: accepts a word on
// LOAD/READY, shifts it out on x, then holds IDLE_LEVEL for the inter-frame gap.
module bit_serializer
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned GAP_CYCLES = 1,
   parameter logic        IDLE_LEVEL = 1'b0,
   parameter bit          MSB_FIRST  = 1'b1
) (
   input  logic                        CLK,
   input  logic                        RESET_N,
   input  logic [WIDTH-1:0]            DATA,
   input  logic                        LOAD,
   output logic                        READY,
   output logic                        x,
   output logic                        BUSY,
   output logic                        DONE,
   output logic [idx_width(WIDTH)-1:0] BIT_IDX
);

   localparam int IDX_W = idx_width(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
      GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

   state_t                 state;
   state_t                 next_state;
   logic [WIDTH-1:0]       shreg;
   logic [WIDTH-1:0]       shreg_nxt;
   logic [GAP_CNT_W-1:0]   gap_cnt;
   logic [GAP_CNT_W-1:0]   gap_nxt;
   logic                   x_nxt;
   logic                   ready_nxt;
   logic                   busy_nxt;
   logic                   done_nxt;
   logic [IDX_W-1:0]       idx_nxt;

   // The bit that goes on x next is always kept at the leading end of shreg
   function automatic logic lead(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? (v << 1) : (v >> 1);
   endfunction

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state   <= ST_IDLE;
         x       <= IDLE_LEVEL;
         READY   <= 1'b1;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         BIT_IDX <= '0;
         shreg   <= '0;
         gap_cnt <= '0;
      end else begin
         state   <= next_state;
         x       <= x_nxt;
         READY   <= ready_nxt;
         BUSY    <= busy_nxt;
         DONE    <= done_nxt;
         BIT_IDX <= idx_nxt;
         shreg   <= shreg_nxt;
         gap_cnt <= gap_nxt;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (LOAD) next_state = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (BIT_IDX == LAST_IDX) next_state = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
         end
         ST_GAP: begin
            if (gap_cnt == '0) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Outputs are computed one cycle ahead so every port comes straight off a flop
   always_comb begin
      x_nxt     = IDLE_LEVEL;
      ready_nxt = (next_state == ST_IDLE);
      busy_nxt  = (next_state != ST_IDLE);
      done_nxt  = 1'b0;
      idx_nxt   = '0;
      shreg_nxt = shreg;
      gap_nxt   = gap_cnt;
      case (state)
         ST_IDLE: begin
            if (LOAD) begin
               x_nxt     = lead(DATA);
               shreg_nxt = advance(DATA);
            end
         end
         ST_SHIFT: begin
            if (BIT_IDX != LAST_IDX) begin
               x_nxt     = lead(shreg);
               shreg_nxt = advance(shreg);
               idx_nxt   = BIT_IDX + IDX_W'(1);
               done_nxt  = (idx_nxt == LAST_IDX);
            end else begin
               shreg_nxt = '0;
               gap_nxt   = GAP_LOAD;
            end
         end
         ST_GAP: begin
            if (gap_cnt != '0) gap_nxt = gap_cnt - GAP_CNT_W'(1);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: three configurations driven with
// directed and random frames against a cycle-position reference model.
module tb_bit_serializer;

   logic       clk = 1'b0;
   logic       rstN;
   logic [2:0] loadV;
   logic [2:0] xV;
   logic [2:0] readyV;
   logic [2:0] busyV;
   logic [2:0] doneV;
   logic [7:0] dataV [3];
   logic [2:0] idxV  [3];

   int checks   = 0;
   int failures = 0;

   logic [7:0] frames [8];
   bit         msbCfg  [3] = '{1'b1, 1'b0, 1'b1};
   int         gapCfg  [3] = '{1, 1, 0};
   logic       idleCfg [3] = '{1'b0, 1'b0, 1'b1};

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(8)) dut0 (
      .CLK(clk), .RESET_N(rstN), .DATA(dataV[0]), .LOAD(loadV[0]), .READY(readyV[0]),
      .x(xV[0]), .BUSY(busyV[0]), .DONE(doneV[0]), .BIT_IDX(idxV[0]));

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
      .CLK(clk), .RESET_N(rstN), .DATA(dataV[1]), .LOAD(loadV[1]), .READY(readyV[1]),
      .x(xV[1]), .BUSY(busyV[1]), .DONE(doneV[1]), .BIT_IDX(idxV[1]));

   bit_serializer #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) dut2 (
      .CLK(clk), .RESET_N(rstN), .DATA(dataV[2]), .LOAD(loadV[2]), .READY(readyV[2]),
      .x(xV[2]), .BUSY(busyV[2]), .DONE(doneV[2]), .BIT_IDX(idxV[2]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input int sel, input string tag, input logic expX, input logic expReady,
                           input logic expBusy, input logic expDone, input logic [2:0] expIdx);
      checkOutput($sformatf("d%0d.%s.x", sel, tag), 32'(xV[sel]), 32'(expX));
      checkOutput($sformatf("d%0d.%s.ready", sel, tag), 32'(readyV[sel]), 32'(expReady));
      checkOutput($sformatf("d%0d.%s.busy", sel, tag), 32'(busyV[sel]), 32'(expBusy));
      checkOutput($sformatf("d%0d.%s.done", sel, tag), 32'(doneV[sel]), 32'(expDone));
      checkOutput($sformatf("d%0d.%s.idx", sel, tag), 32'(idxV[sel]), 32'(expIdx));
   endtask

   // Holds LOAD high for nFrames back-to-back frames; DATA for the next frame is
   // presented mid-frame, so it must not disturb the frame currently on x.
   task automatic applyStimulus(input int sel, input string step, input int nFrames);
      int         period;
      int         f;
      int         pos;
      logic [7:0] w;
      logic       expX;
      period = 8 + gapCfg[sel] + 1;
      dataV[sel] = frames[0];
      loadV[sel] = 1'b1;
      tick();
      for (int c = 1; c <= nFrames * period; c++) begin
         f   = (c - 1) / period;
         pos = (c - 1) % period;
         w   = frames[f];
         if (pos < 8) expX = msbCfg[sel] ? w[7 - pos] : w[pos];
         else         expX = idleCfg[sel];
         checkAll(sel, $sformatf("%s.c%0d", step, c), expX, pos == period - 1,
                  pos < 8 + gapCfg[sel], pos == 7, (pos < 8) ? 3'(pos) : 3'd0);
         if (pos == 2) dataV[sel] = (f + 1 < nFrames) ? frames[f + 1] : 8'($urandom);
         if (c == nFrames * period) loadV[sel] = 1'b0;
         tick();
      end
      checkAll(sel, $sformatf("%s.end", step), idleCfg[sel], 1'b1, 1'b0, 1'b0, 3'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int nf;
      int idle;

      // Reset held with LOAD asserted must not start a frame
      rstN  = 1'b0;
      loadV = 3'b111;
      for (int s = 0; s < 3; s++) dataV[s] = 8'hFF;
      tick();
      for (int s = 0; s < 3; s++) checkAll(s, "rst1", idleCfg[s], 1'b1, 1'b0, 1'b0, 3'd0);
      tick();
      for (int s = 0; s < 3; s++) checkAll(s, "rst2", idleCfg[s], 1'b1, 1'b0, 1'b0, 3'd0);
      loadV = 3'b000;
      rstN  = 1'b1;
      tick();
      for (int s = 0; s < 3; s++) checkAll(s, "post", idleCfg[s], 1'b1, 1'b0, 1'b0, 3'd0);

      frames[0] = 8'hA5;
      applyStimulus(0, "a5", 1);

      frames[0] = 8'hFF;
      frames[1] = 8'h00;
      applyStimulus(0, "b2b", 2);

      // Reset in the middle of a frame aborts it without a DONE pulse
      dataV[0] = 8'hF0;
      loadV[0] = 1'b1;
      tick();
      loadV[0] = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         checkAll(0, $sformatf("abort.c%0d", c), 1'b1, 1'b0, 1'b1, 1'b0, 3'(c - 1));
         if (c == 4) rstN = 1'b0;
         tick();
      end
      checkAll(0, "abort.rst", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
      rstN = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checkAll(0, $sformatf("abort.after%0d", c), 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
      end

      frames[0] = 8'h01;
      applyStimulus(1, "lsb01", 1);

      frames[0] = 8'h00;
      frames[1] = 8'h00;
      frames[2] = 8'h00;
      applyStimulus(2, "gap0", 3);

      // Random frames on every configuration with random idle spacing
      for (int s = 0; s < 3; s++) begin
         for (int r = 0; r < 4; r++) begin
            nf = int'($urandom_range(1, 3));
            for (int i = 0; i < nf; i++) frames[i] = 8'($urandom);
            applyStimulus(s, $sformatf("rnd%0d", r), nf);
            idle = int'($urandom_range(0, 2));
            for (int i = 0; i < idle; i++) begin
               dataV[s] = 8'($urandom);
               tick();
               checkAll(s, $sformatf("rnd%0d.idle%0d", r, i), idleCfg[s], 1'b1, 1'b0, 1'b0, 3'd0);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
